mem_align_seq: RTL and testbench

- Sits between the EX/MEM pipeline register and the data-memory block.
- The data memory accepts only naturally aligned loads and stores.
- This block passes aligned accesses straight through. It converts each misaligned load or store into a sequence of single-byte accesses, stalls the pipeline while the sequence runs, and assembles and sign- or zero-extends misaligned load results.
- It owns the load-result path back into the pipeline.

---
 rtl/mem_align_seq_if.sv | 38 +++
 rtl/mem_align_seq.sv | 201 ++++++++++++++++++++
 tb/tb_mem_align_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_align_seq_if.sv
// mem_align_seq_if: pipeline-side request/result signals and data-memory
// signals of mem_align_seq, bundled so both ends share one definition.
interface mem_align_seq_if #(
  parameter int ADDR_W = 64
);
  // Pipeline request (EX/MEM)
  logic              we_i;
  logic              re_i;
  logic [ADDR_W-1:0] addr_i;
  logic [63:0]       data_i;
  logic [2:0]        func3_i;
  // Pipeline control and load result
  logic              stall_o;
  logic              fault_o;
  logic [63:0]       ld_data_o;
  logic              ld_valid_o;
  // Data-memory side
  logic              dm_we;
  logic              dm_re;
  logic [ADDR_W-1:0] dm_addr;
  logic [63:0]       dm_data;
  logic [2:0]        dm_func3;
  logic [63:0]       dm_rdata;

  // The aligner itself
  modport slave (
    input  we_i, re_i, addr_i, data_i, func3_i, dm_rdata,
    output stall_o, fault_o, ld_data_o, ld_valid_o,
           dm_we, dm_re, dm_addr, dm_data, dm_func3
  );

  // The environment: pipeline plus data memory
  modport master (
    output we_i, re_i, addr_i, data_i, func3_i, dm_rdata,
    input  stall_o, fault_o, ld_data_o, ld_valid_o,
           dm_we, dm_re, dm_addr, dm_data, dm_func3
  );
endinterface

// File: rtl/mem_align_seq.sv
// mem_align_seq: passes naturally aligned loads/stores straight to the data
// memory and turns misaligned ones into a stalled sequence of byte accesses,
// assembling and extending misaligned load results.
module mem_align_seq #(
  parameter int ADDR_W      = 64,
  parameter bit EN_MISALIGN = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  mem_align_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPLIT = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_LBU = 3'b100;

  state_t r_state;
  state_t w_next_state;

  // Latched copy of the accepted misaligned access
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_data;
  logic [2:0]        r_func3;
  logic              r_is_store;
  logic [2:0]        r_last_idx;   // access size minus one
  logic [2:0]        r_idx;        // byte currently issued
  // Load assembly: one byte lane per issued byte, filled a cycle after issue
  logic [63:0]       r_asm;
  logic              r_cap_valid;
  logic [2:0]        r_cap_lane;
  // Aligned load issued last cycle; its data is on dm_rdata now
  logic              r_ld_pend;

  logic       w_req;
  logic       w_is_store;
  logic [2:0] w_last_idx;
  logic       w_aligned;
  logic       w_pass;
  logic       w_accept;
  logic       w_seq_last;

  // Extend the assembled bytes according to the latched load func3
  function automatic logic [63:0] extend_load(input logic [63:0] raw,
                                              input logic [2:0]  f3);
    logic [63:0] res;
    case (f3)
      3'b001:  res = {{48{raw[15]}}, raw[15:0]};
      3'b010:  res = {{32{raw[31]}}, raw[31:0]};
      3'b101:  res = {48'd0, raw[15:0]};
      3'b110:  res = {32'd0, raw[31:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Decode the incoming request: size, alignment, pass-through or split
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a value on
    // every path (defaults first), otherwise a latch is inferred.
    w_last_idx = 3'd0;
    case (bus.func3_i[1:0])
      2'b00:   w_last_idx = 3'd0;
      2'b01:   w_last_idx = 3'd1;
      2'b10:   w_last_idx = 3'd3;
      default: w_last_idx = 3'd7;
    endcase
    w_req      = bus.we_i | bus.re_i;
    w_is_store = bus.we_i;
    // func3 111 never comes from a legal decode; it is simply passed through
    w_aligned  = ((bus.addr_i[2:0] & w_last_idx) == 3'b000) ||
                 (bus.func3_i == 3'b111);
    w_pass     = (r_state == S_IDLE) && w_req && w_aligned;
    w_accept   = (r_state == S_IDLE) && w_req && !w_aligned && EN_MISALIGN;
    w_seq_last = (r_idx == r_last_idx);
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and updates together.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_SPLIT;
      S_SPLIT: if (w_seq_last) w_next_state = r_is_store ? S_DONE : S_DRAIN;
      S_DRAIN: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Latch the accepted access, step the byte index and capture load bytes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the assembly register and latched request are cleared too, so
      // nothing from an aborted sequence can leak into a later result.
      r_addr      <= '0;
      r_data      <= '0;
      r_func3     <= '0;
      r_is_store  <= 1'b0;
      r_last_idx  <= '0;
      r_idx       <= '0;
      r_asm       <= '0;
      r_cap_valid <= 1'b0;
      r_cap_lane  <= '0;
      r_ld_pend   <= 1'b0;
    end else begin
      r_ld_pend   <= w_pass && !w_is_store;
      r_cap_valid <= 1'b0;

      if (w_accept) begin
        r_addr     <= bus.addr_i;
        r_data     <= bus.data_i;
        r_func3    <= bus.func3_i;
        r_is_store <= w_is_store;
        r_last_idx <= w_last_idx;
        r_idx      <= 3'd0;
        r_asm      <= '0;
      end

      if (r_state == S_SPLIT) begin
        r_idx       <= r_idx + 3'd1;
        r_cap_valid <= !r_is_store;
        r_cap_lane  <= r_idx;
      end

      if (r_cap_valid) begin
        r_asm[{r_cap_lane, 3'b000} +: 8] <= bus.dm_rdata[7:0];
      end
    end
  end

  // Drive memory, stall, fault and load-result outputs; all forced low while
  // reset is asserted so no byte is written in the reset cycle itself.
  always_comb begin
    bus.stall_o    = 1'b0;
    bus.fault_o    = 1'b0;
    bus.dm_we      = 1'b0;
    bus.dm_re      = 1'b0;
    bus.dm_addr    = '0;
    bus.dm_data    = '0;
    bus.dm_func3   = '0;
    bus.ld_valid_o = 1'b0;
    bus.ld_data_o  = '0;

    if (rst_n) begin
      if (r_ld_pend) begin
        bus.ld_valid_o = 1'b1;
        bus.ld_data_o  = bus.dm_rdata;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pass) begin
            bus.dm_we    = w_is_store;
            bus.dm_re    = !w_is_store;
            bus.dm_addr  = bus.addr_i;
            bus.dm_data  = bus.data_i;
            bus.dm_func3 = bus.func3_i;
          end else if (w_accept) begin
            bus.stall_o = 1'b1;
          end else if (w_req) begin
            bus.fault_o = 1'b1;
          end
        end
        S_SPLIT: begin
          bus.stall_o  = 1'b1;
          bus.dm_we    = r_is_store;
          bus.dm_re    = !r_is_store;
          bus.dm_addr  = r_addr + ADDR_W'(r_idx);
          bus.dm_func3 = r_is_store ? F3_SB : F3_LBU;
          if (r_is_store) begin
            bus.dm_data = {56'd0, r_data[{r_idx, 3'b000} +: 8]};
          end
        end
        S_DRAIN: begin
          bus.stall_o = 1'b1;
        end
        S_DONE: begin
          if (!r_is_store) begin
            bus.ld_valid_o = 1'b1;
            bus.ld_data_o  = extend_load(r_asm, r_func3);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_align_seq.sv
// tb_mem_align_seq: directed vector table, hand-written reset/fault sequences
// and randomized accesses checked against a byte-array memory model.
module tb_mem_align_seq;

  localparam int ADDR_W = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_align_seq_if #(.ADDR_W(ADDR_W)) bus ();
  mem_align_seq_if #(.ADDR_W(ADDR_W)) bus_nf ();

  mem_align_seq #(.ADDR_W(ADDR_W), .EN_MISALIGN(1'b1)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  mem_align_seq #(.ADDR_W(ADDR_W), .EN_MISALIGN(1'b0)) u_dut_nf (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_nf)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Data memory seen by the DUT (4 KiB, aliased) and the reference copy
  logic [7:0]  mem    [0:4095] = '{default: 8'h00};
  logic [7:0]  shadow [0:4095] = '{default: 8'h00};
  logic [63:0] mem_rdata = '0;

  assign bus.dm_rdata    = mem_rdata;
  assign bus_nf.dm_rdata = '0;

  function automatic int nbytes(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic logic [63:0] load_ext(input logic [63:0] raw, input logic [2:0] f);
    case (f)
      3'b000:  return {{56{raw[7]}},  raw[7:0]};
      3'b001:  return {{48{raw[15]}}, raw[15:0]};
      3'b010:  return {{32{raw[31]}}, raw[31:0]};
      3'b100:  return {56'd0, raw[7:0]};
      3'b101:  return {48'd0, raw[15:0]};
      3'b110:  return {32'd0, raw[31:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [63:0] mem_read(input logic [63:0] a, input logic [2:0] f);
    logic [63:0] raw;
    raw = '0;
    for (int k = 0; k < nbytes(f); k++) raw[8*k +: 8] = mem[12'(a + 64'(k))];
    return load_ext(raw, f);
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] f);
    logic [63:0] raw;
    raw = '0;
    for (int k = 0; k < nbytes(f); k++) raw[8*k +: 8] = shadow[12'(a + 64'(k))];
    return load_ext(raw, f);
  endfunction

  function automatic void shadow_store(input logic [63:0] a, input logic [63:0] d,
                                       input logic [2:0] f);
    for (int k = 0; k < nbytes(f); k++) shadow[12'(a + 64'(k))] = d[8*k +: 8];
  endfunction

  // Behavioural data memory: aligned-only accesses, read data one cycle later
  always @(posedge clk) begin
    if (bus.dm_we) begin
      for (int k = 0; k < nbytes(bus.dm_func3); k++)
        mem[12'(bus.dm_addr + 64'(k))] <= bus.dm_data[8*k +: 8];
    end
    if (bus.dm_re) mem_rdata <= mem_read(bus.dm_addr, bus.dm_func3);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.we_i = 1'b0; bus.re_i = 1'b0; bus.addr_i = '0; bus.data_i = '0; bus.func3_i = '0;
  endtask

  // Present one access like the pipeline would (held while stalled), count
  // stall cycles and collect the load result wherever it appears.
  task automatic do_op(input logic we, input logic re, input logic [63:0] addr,
                       input logic [63:0] data, input logic [2:0] f,
                       output int stalls, output logic valid, output logic [63:0] ldata);
    stalls = 0; valid = 1'b0; ldata = '0;
    @(negedge clk);
    bus.we_i = we; bus.re_i = re; bus.addr_i = addr; bus.data_i = data; bus.func3_i = f;
    #1;
    while (bus.stall_o && stalls < 20) begin
      stalls++;
      @(negedge clk); #1;
    end
    if (stalls >= 20) check("op_stall_bound", 64'(bus.stall_o), 64'd0);
    if (stalls > 0) begin
      valid = bus.ld_valid_o; ldata = bus.ld_data_o;
    end
    @(negedge clk);
    idle_inputs();
    if (stalls == 0) begin
      #1; valid = bus.ld_valid_o; ldata = bus.ld_data_o;
    end
  endtask

  typedef struct packed {
    logic        we;
    logic        re;
    logic [63:0] addr;
    logic [63:0] data;
    logic [2:0]  f;
    logic [4:0]  exp_stall;
    logic        exp_valid;
    logic [63:0] exp_ld;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic re, input logic [63:0] a,
                              input logic [63:0] d, input logic [2:0] f,
                              input logic [4:0] st, input logic [63:0] ld);
    vec_t v;
    v.we = we; v.re = re; v.addr = a; v.data = d; v.f = f;
    v.exp_stall = st; v.exp_valid = !we; v.exp_ld = we ? 64'd0 : ld;
    return v;
  endfunction

  localparam int NVEC = 18;
  vec_t        vecs [NVEC];
  int          st;
  logic        vld;
  logic [63:0] ld;
  logic        r_we, r_re, r_al;
  logic [2:0]  r_f;
  logic [63:0] r_a, r_d, r_exp;
  int          r_sz, r_st;

  initial begin
    // Directed table: order matters, later entries rely on earlier stores
    vecs[0]  = mk(0, 1, 64'h100, 0, 3'b011, 0, 64'h1122334455667788);
    vecs[1]  = mk(1, 0, 64'h103, 64'hAABBCCDD, 3'b010, 5, 0);
    vecs[2]  = mk(0, 1, 64'h104, 0, 3'b010, 0, 64'h0000000011AABBCC);
    vecs[3]  = mk(0, 1, 64'h103, 0, 3'b100, 0, 64'h00000000000000DD);
    vecs[4]  = mk(1, 0, 64'h107, 64'h34, 3'b000, 0, 0);
    vecs[5]  = mk(1, 0, 64'h108, 64'h92, 3'b000, 0, 0);
    vecs[6]  = mk(0, 1, 64'h107, 0, 3'b001, 4, 64'hFFFFFFFFFFFF9234);
    vecs[7]  = mk(0, 1, 64'h107, 0, 3'b101, 4, 64'h0000000000009234);
    vecs[8]  = mk(0, 1, 64'h0FD, 0, 3'b011, 10, 64'hCCDD667788A3A2A1);
    vecs[9]  = mk(1, 0, 64'h109, 64'h0123456789ABCDEF, 3'b011, 9, 0);
    vecs[10] = mk(0, 1, 64'h108, 0, 3'b011, 0, 64'h23456789ABCDEF92);
    vecs[11] = mk(0, 1, 64'h109, 0, 3'b010, 6, 64'hFFFFFFFF89ABCDEF);
    vecs[12] = mk(0, 1, 64'h109, 0, 3'b110, 6, 64'h0000000089ABCDEF);
    vecs[13] = mk(1, 0, 64'h0F1, 64'hBEEF, 3'b001, 3, 0);
    vecs[14] = mk(0, 1, 64'h0F1, 0, 3'b001, 4, 64'hFFFFFFFFFFFFBEEF);
    vecs[15] = mk(0, 1, 64'hFFFFFFFFFFFFFFFF, 0, 3'b001, 4, 64'hFFFFFFFFFFFF805A);
    vecs[16] = mk(1, 1, 64'h0F3, 64'h1234, 3'b001, 3, 0);
    vecs[17] = mk(0, 1, 64'h0F3, 0, 3'b101, 4, 64'h0000000000001234);

    idle_inputs();
    bus_nf.we_i = 1'b0; bus_nf.re_i = 1'b0; bus_nf.addr_i = '0;
    bus_nf.data_i = '0; bus_nf.func3_i = '0;

    // Reset: every output low in IDLE afterwards
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_stall",    64'(bus.stall_o),    0);
    check("rst_fault",    64'(bus.fault_o),    0);
    check("rst_dm_we",    64'(bus.dm_we),      0);
    check("rst_dm_re",    64'(bus.dm_re),      0);
    check("rst_dm_addr",  bus.dm_addr,         0);
    check("rst_dm_data",  bus.dm_data,         0);
    check("rst_dm_func3", 64'(bus.dm_func3),   0);
    check("rst_ld_data",  bus.ld_data_o,       0);
    check("rst_ld_valid", 64'(bus.ld_valid_o), 0);

    // Preload memory through aligned pass-through stores
    do_op(1, 0, 64'h100, 64'h1122334455667788, 3'b011, st, vld, ld);
    shadow_store(64'h100, 64'h1122334455667788, 3'b011);
    do_op(1, 0, 64'h0FD, 64'hA1, 3'b000, st, vld, ld); shadow_store(64'h0FD, 64'hA1, 3'b000);
    do_op(1, 0, 64'h0FE, 64'hA2, 3'b000, st, vld, ld); shadow_store(64'h0FE, 64'hA2, 3'b000);
    do_op(1, 0, 64'h0FF, 64'hA3, 3'b000, st, vld, ld); shadow_store(64'h0FF, 64'hA3, 3'b000);
    do_op(1, 0, 64'hFFF, 64'h5A, 3'b000, st, vld, ld); shadow_store(64'hFFF, 64'h5A, 3'b000);
    do_op(1, 0, 64'h000, 64'h80, 3'b000, st, vld, ld); shadow_store(64'h000, 64'h80, 3'b000);

    // Aligned LD pass-through in the same cycle, data the next cycle
    @(negedge clk);
    bus.re_i = 1'b1; bus.addr_i = 64'h100; bus.func3_i = 3'b011;
    #1;
    check("pass_dm_re",    64'(bus.dm_re),    1);
    check("pass_dm_we",    64'(bus.dm_we),    0);
    check("pass_dm_addr",  bus.dm_addr,       64'h100);
    check("pass_dm_func3", 64'(bus.dm_func3), 64'h3);
    check("pass_stall",    64'(bus.stall_o),  0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("pass_ld_valid", 64'(bus.ld_valid_o), 1);
    check("pass_ld_data",  bus.ld_data_o,       64'h1122334455667788);

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      do_op(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].data, vecs[i].f, st, vld, ld);
      if (vecs[i].we) shadow_store(vecs[i].addr, vecs[i].data, vecs[i].f);
      check($sformatf("vec%0d_stall", i), 64'(st), 64'(vecs[i].exp_stall));
      check($sformatf("vec%0d_valid", i), 64'(vld), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("vec%0d_ld", i), ld, vecs[i].exp_ld);
    end

    // Reset during the 3rd SPLIT cycle of a misaligned SW
    @(negedge clk);
    bus.we_i = 1'b1; bus.addr_i = 64'h203; bus.data_i = 64'h11223344; bus.func3_i = 3'b010;
    #1;
    check("mid_accept_stall", 64'(bus.stall_o), 1);
    check("mid_accept_we",    64'(bus.dm_we),   0);
    @(negedge clk); #1;
    check("mid_split0_we",    64'(bus.dm_we),    1);
    check("mid_split0_addr",  bus.dm_addr,       64'h203);
    check("mid_split0_func3", 64'(bus.dm_func3), 0);
    check("mid_split0_data",  bus.dm_data,       64'h44);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("mid_rst_cycle_we", 64'(bus.dm_we), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_after_stall", 64'(bus.stall_o),    0);
    check("mid_after_we",    64'(bus.dm_we),      0);
    check("mid_after_valid", 64'(bus.ld_valid_o), 0);
    check("mid_mem_203", 64'(mem[12'h203]), 64'h44);
    check("mid_mem_204", 64'(mem[12'h204]), 64'h33);
    check("mid_mem_205", 64'(mem[12'h205]), 64'h00);
    check("mid_mem_206", 64'(mem[12'h206]), 64'h00);
    shadow[12'h203] = 8'h44;
    shadow[12'h204] = 8'h33;

    // EN_MISALIGN=0: misaligned LW faults for one cycle, no memory access
    @(negedge clk);
    bus_nf.re_i = 1'b1; bus_nf.addr_i = 64'h102; bus_nf.func3_i = 3'b010;
    #1;
    check("nf_fault",    64'(bus_nf.fault_o),    1);
    check("nf_dm_we",    64'(bus_nf.dm_we),      0);
    check("nf_dm_re",    64'(bus_nf.dm_re),      0);
    check("nf_stall",    64'(bus_nf.stall_o),    0);
    check("nf_ld_valid", 64'(bus_nf.ld_valid_o), 0);
    @(negedge clk);
    bus_nf.re_i = 1'b0; bus_nf.addr_i = '0; bus_nf.func3_i = '0;
    #1;
    check("nf_fault_clr",  64'(bus_nf.fault_o),    0);
    check("nf_ld_valid_2", 64'(bus_nf.ld_valid_o), 0);
    @(negedge clk);
    bus_nf.re_i = 1'b1; bus_nf.addr_i = 64'h104; bus_nf.func3_i = 3'b010;
    #1;
    check("nf_aligned_fault", 64'(bus_nf.fault_o), 0);
    check("nf_aligned_re",    64'(bus_nf.dm_re),   1);
    @(negedge clk);
    bus_nf.re_i = 1'b0; bus_nf.addr_i = '0; bus_nf.func3_i = '0;

    // Randomized accesses against the byte-array model
    for (int n = 0; n < 150; n++) begin
      r_we = 1'($urandom_range(0, 1));
      r_re = r_we ? ($urandom_range(0, 2) == 0) : 1'b1;
      r_f  = r_we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      r_a  = 64'h300 + 64'($urandom_range(0, 224));
      r_d  = {$urandom, $urandom};
      r_sz = nbytes(r_f);
      r_al = (r_a % 64'(r_sz)) == 0;
      r_st = r_al ? 0 : (r_we ? r_sz + 1 : r_sz + 2);
      r_exp = r_we ? 64'd0 : model_load(r_a, r_f);
      do_op(r_we, r_re, r_a, r_d, r_f, st, vld, ld);
      if (r_we) shadow_store(r_a, r_d, r_f);
      check($sformatf("rnd%0d_stall", n), 64'(st),  64'(r_st));
      check($sformatf("rnd%0d_valid", n), 64'(vld), 64'(!r_we));
      if (!r_we) check($sformatf("rnd%0d_ld a=%0h f=%0d", n, r_a, r_f), ld, r_exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hang guard
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
